pattern_rom_seq: RTL
====================

PATTERN_ROM_SEQ -- requirements
Module: pattern_rom_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the output word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of addressable words, legal range 2..WIDTH.
REQ-003 The block SHALL have parameter AW, default 3, meaning the address width, equal to clog2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, 1 bit: start-burst strobe, sampled only in IDLE.
REQ-007 The block SHALL have port addr, input, AW bits: start address of the burst.
REQ-008 The block SHALL have port len, input, AW bits: burst length in words; 0 encodes DEPTH.
REQ-009 The block SHALL have port mode, input, 2 bits: pattern select, latched at burst start.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-011 The block SHALL have port dout, output, WIDTH bits: registered pattern word.
REQ-012 The block SHALL have port dout_valid, output, 1 bit: dout holds a burst word this cycle.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse coincident with the last word.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse on a rejected request.

Function
REQ-015 The word at address a SHALL be generated as follows. Mode 0 is one-hot: bit a set. Mode 1 is thermometer: bits 0..a set. Mode 2 is reverse one-hot: bit WIDTH-1-a set. Mode 3 is inverted one-hot: all bits set except bit a.
REQ-016 The FSM SHALL have the states IDLE and READ; reset enters IDLE.
REQ-017 In IDLE, req=1 with addr<DEPTH SHALL latch addr, len and mode, enter READ, and set busy=1 on the next edge.
REQ-018 In IDLE, req=1 with addr>=DEPTH SHALL be rejected: err=1 for one cycle, the FSM stays in IDLE and dout is unchanged.
REQ-019 Latency SHALL be as follows: req sampled at edge n gives the first word with dout_valid=1 after edge n+1. Exactly one word SHALL be produced per cycle with no gaps.
REQ-020 The read address SHALL increment by 1 per word and wrap from DEPTH-1 to 0.
REQ-021 A burst SHALL produce exactly len words, or DEPTH words when len=0.
REQ-022 On the last word, done=1 and dout_valid=1 in the same cycle; the next edge SHALL return the FSM to IDLE with busy=0 and dout_valid=0.
REQ-023 req SHALL be ignored while busy=1; no queuing is performed.
REQ-024 A new req SHALL be accepted in the cycle after done, so back-to-back bursts have a one-cycle gap.
REQ-025 Changes to addr, len and mode during READ SHALL have no effect on the burst in progress.
REQ-026 dout SHALL hold its last value while dout_valid=0.
REQ-027 done and err SHALL never be asserted in the same cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, dout=0, dout_valid=0, done=0 and err=0, independent of clk.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block SHALL accept req on the first active edge.

Configuration
REQ-030 With macro PATTERN_ROM_PARITY_EN defined, the block SHALL add output dout_par, 1 bit. dout_par is the even parity (XOR) of dout, registered alongside dout, and is 0 at reset.
REQ-031 Without PATTERN_ROM_PARITY_EN, the dout_par port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Test with defaults: mode=0, addr=5, len=3 -> dout 0x20, 0x40, 0x80 on three consecutive cycles with dout_valid=1; done=1 on 0x80; busy=0 afterwards.
REQ-033 Wrap test: mode=1, addr=6, len=4 -> dout 0x7F, 0xFF, 0x01, 0x03; done on 0x03.
REQ-034 Full-length test: mode=3, addr=0, len=0 -> 8 words, 0xFE through 0x7F; done on word 8; a req issued during the burst is ignored.
REQ-035 Rejection test: DEPTH=6, addr=7 -> err pulses for one cycle, busy stays 0, dout is unchanged.
REQ-036 Reset test: rst_n pulled low during the 2nd word of a len=5 burst -> all outputs 0 asynchronously; no done pulse; a req after release starts a fresh burst.
REQ-037 Parity test, with PATTERN_ROM_PARITY_EN defined: mode=1, addr=2 -> dout 0x07 with dout_par=1; mode=0 -> dout_par=1 on every word.

Source files
------------

// File: rtl/pattern_rom_seq.sv
// Burst sequencer that streams computed pattern words (one-hot, thermometer, reverse
// one-hot, inverted one-hot). Define PATTERN_ROM_PARITY_EN to add the registered dout_par output.
module pattern_rom_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [AW-1:0]    addr,
  input  logic [AW-1:0]    len,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             done,
  output logic             err
`ifdef PATTERN_ROM_PARITY_EN
  ,
  output logic             dout_par
`endif
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);

  state_t           state, state_next;
  logic [AW-1:0]    rd_addr, rd_addr_next;
  logic [AW:0]      remaining, remaining_next;
  logic [1:0]       mode_q, mode_next;
  logic [WIDTH-1:0] dout_next;
  logic             valid_next, done_next, err_next;
  logic             addr_ok;

  function automatic logic [WIDTH-1:0] pattern_word(input logic [1:0] m, input logic [AW-1:0] a);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (m)
        2'd0:    w[i] = (i == int'(a));
        2'd1:    w[i] = (i <= int'(a));
        2'd2:    w[i] = (i == WIDTH - 1 - int'(a));
        default: w[i] = (i != int'(a));
      endcase
    end
    return w;
  endfunction

  assign addr_ok = ({1'b0, addr} < DEPTH_W);
  assign busy    = (state == READ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The FSM stays in READ for the cycle that shows the last word, so a done
  // pulse is always followed by one IDLE cycle before a new burst can start.
  always_comb begin
    state_next     = state;
    rd_addr_next   = rd_addr;
    remaining_next = remaining;
    mode_next      = mode_q;
    dout_next      = dout;
    valid_next     = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (addr_ok) begin
            state_next     = READ;
            rd_addr_next   = addr;
            remaining_next = (len == '0) ? DEPTH_W : {1'b0, len};
            mode_next      = mode;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      READ: begin
        if (done) begin
          state_next = IDLE;
        end else begin
          dout_next      = pattern_word(mode_q, rd_addr);
          valid_next     = 1'b1;
          done_next      = (remaining == ONE_W);
          remaining_next = remaining - ONE_W;
          rd_addr_next   = (rd_addr == LAST) ? '0 : rd_addr + AW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      remaining  <= '0;
      mode_q     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_addr    <= rd_addr_next;
      remaining  <= remaining_next;
      mode_q     <= mode_next;
      dout       <= dout_next;
      dout_valid <= valid_next;
      done       <= done_next;
      err        <= err_next;
    end
  end

`ifdef PATTERN_ROM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_par <= 1'b0;
    else        dout_par <= ^dout_next;
  end
`endif

endmodule
